vga_cell_scanner: RTL and testbench

//  Downstream consumer of the 1200-bit, 40x30-cell framebuffer produced by the Display stage.

---
 rtl/vga_cell_scanner.sv | 165 ++++++++++++++++
 tb/tb_vga_cell_scanner.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_cell_scanner.sv
// 640x480@60 scanner for the 40x30 cell framebuffer: each cell becomes a 16x16 pixel block.
// Define VGA_GRID_EN to draw a grey grid on the first row and column of every unlit cell.
module vga_cell_scanner #(
    parameter int          CLK_DIV   = 2,
    parameter int          H_VISIBLE = 640,
    parameter int          H_FRONT   = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BACK    = 48,
    parameter int          V_VISIBLE = 480,
    parameter int          V_FRONT   = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BACK    = 33,
    parameter logic [11:0] FG_RGB    = 12'hFFF,
    parameter logic [11:0] BG_RGB    = 12'h000
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [1199:0] framebuffer,
    output logic [3:0]    vga_r,
    output logic [3:0]    vga_g,
    output logic [3:0]    vga_b,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic [5:0]    cell_x,
    output logic [4:0]    cell_y,
    output logic          frame_start
);
    localparam int STAGES = 2;
    localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [11:0] GRID_RGB = 12'h444;

    typedef struct packed {
        logic [5:0] col;
        logic [4:0] row;
        logic       grid;
        logic       hs_n;
        logic       vs_n;
    } s1_t;

    localparam s1_t S1_RST = '{col: 6'd0, row: 5'd0, grid: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

    logic [DW-1:0]     div;
    logic              pe;
    logic [9:0]        h_count;
    logic [9:0]        v_count;
    logic              h_wrap;
    logic              v_wrap;
    logic [1199:0]     shadow;
    logic              vis0;
    logic              grid0;
    s1_t               s1_d;
    s1_t               s1_q;
    logic [STAGES:1]   vld_pipe;
    logic [10:0]       row_ext;
    logic [10:0]       idx;
    logic              lit;
    logic [11:0]       rgb_q;

    // Pixel enable
    assign pe = (div == DIV_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            div <= '0;
        else if (pe)
            div <= '0;
        else
            div <= div + DW'(1);
    end

    // Stage 0: raster counters
    assign h_wrap = (h_count == H_LAST);
    assign v_wrap = (v_count == V_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_count <= '0;
            v_count <= '0;
        end else if (pe) begin
            if (h_wrap) begin
                h_count <= '0;
                v_count <= v_wrap ? 10'd0 : v_count + 10'd1;
            end else begin
                h_count <= h_count + 10'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            frame_start <= 1'b0;
        else
            frame_start <= pe && h_wrap && v_wrap;
    end

    // Capture the bitmap on the first blanking line so the whole next frame sees one image.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            shadow <= '0;
        else if (pe && h_count == 10'd0 && v_count == V_VIS)
            shadow <= framebuffer;
    end

    assign vis0 = (h_count < H_VIS) && (v_count < V_VIS);

`ifdef VGA_GRID_EN
    assign grid0 = (h_count[3:0] == 4'd0) || (v_count[3:0] == 4'd0);
`else
    assign grid0 = 1'b0;
`endif

    always_comb begin
        s1_d      = S1_RST;
        s1_d.col  = vis0 ? h_count[9:4] : 6'd0;
        s1_d.row  = vis0 ? v_count[8:4] : 5'd0;
        s1_d.grid = grid0;
        s1_d.hs_n = !((h_count >= HS_START) && (h_count < HS_END));
        s1_d.vs_n = !((v_count >= VS_START) && (v_count < VS_END));
    end

    // Stage 1: cell index and sync flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= S1_RST;
            vld_pipe <= '0;
        end else if (pe) begin
            s1_q     <= s1_d;
            vld_pipe <= {vld_pipe[STAGES-1:1], vis0};
        end
    end

    assign cell_x = s1_q.col;
    assign cell_y = s1_q.row;

    // Bit row*40 + 39 - col; blanking pixels carry col=row=0 so the index stays in range.
    assign row_ext = {6'd0, s1_q.row};
    assign idx     = (row_ext << 5) + (row_ext << 3) + 11'd39 - {5'd0, s1_q.col};
    assign lit     = shadow[idx];

    // Stage 2: colour and sync registered together
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q  <= '0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
        end else if (pe) begin
            rgb_q  <= lit ? FG_RGB : (s1_q.grid ? GRID_RGB : BG_RGB);
            vga_hs <= s1_q.hs_n;
            vga_vs <= s1_q.vs_n;
        end
    end

    assign {vga_r, vga_g, vga_b} = vld_pipe[STAGES] ? rgb_q : 12'h000;

endmodule

// File: tb/tb_vga_cell_scanner.sv
// Directed bench: a shrunken-raster instance for frame-level behaviour and a
// full-width instance for the default horizontal timing and the 40-column edge.
`timescale 1ns/1ps
module tb_vga_cell_scanner;
    localparam int HT     = 80;            // 64 + 4 + 8 + 4
    localparam int VT     = 38;            // 32 + 2 + 2 + 2
    localparam int FRAME  = HT * VT * 2;   // 6080 clocks
    localparam int WHT    = 800;
    localparam int WVT    = 19;            // 16 + 1 + 1 + 1
    localparam int WFRAME = WHT * WVT * 2; // 30400 clocks

    logic          clock = 1'b0;
    logic          rst_n, rst_n_w;
    logic [1199:0] fb, fb_w;
    logic [3:0]    r, g, b, r_w, g_w, b_w;
    logic          hs, vs, fs, hs_w, vs_w, fs_w;
    logic [5:0]    cx, cx_w;
    logic [4:0]    cy, cy_w;
    logic [11:0]   rgb, rgb_w;

    int n_chk = 0;
    int n_err = 0;
    int cur   = 0;

    always #5 clock = ~clock;

    assign rgb   = {r, g, b};
    assign rgb_w = {r_w, g_w, b_w};

    vga_cell_scanner #(
        .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_VISIBLE(32), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) u_dut (
        .clock(clock), .reset_n(rst_n), .framebuffer(fb),
        .vga_r(r), .vga_g(g), .vga_b(b), .vga_hs(hs), .vga_vs(vs),
        .cell_x(cx), .cell_y(cy), .frame_start(fs)
    );

    vga_cell_scanner #(
        .V_VISIBLE(16), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_wide (
        .clock(clock), .reset_n(rst_n_w), .framebuffer(fb_w),
        .vga_r(r_w), .vga_g(g_w), .vga_b(b_w), .vga_hs(hs_w), .vga_vs(vs_w),
        .cell_x(cx_w), .cell_y(cy_w), .frame_start(fs_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to edge e (counted from the current raster origin), sample 1ns later.
    task automatic to(input int e);
        if (e > cur) begin
            repeat (e - cur) @(posedge clock);
            #1;
            cur = e;
        end
    endtask

    function automatic logic [11:0] ul(input int h, input int v);
`ifdef VGA_GRID_EN
        return (h % 16 == 0 || v % 16 == 0) ? 12'h444 : 12'h000;
`else
        return (h < 0 || v < 0) ? 12'hBAD : 12'h000;
`endif
    endfunction

    // Colour of pixel (h,v) is on the outputs after edge 2p+4.
    task automatic px(input string tag, input bit w, input int h, input int v, input logic [11:0] exp);
        to(2 * (v * (w ? WHT : HT) + h) + 4);
        chk(tag, 32'(w ? rgb_w : rgb), 32'(exp));
    endtask

    task automatic syn(input string tag, input bit w, input int h, input int v, input bit ehs, input bit evs);
        to(2 * (v * (w ? WHT : HT) + h) + 4);
        chk({tag, "_hs"}, 32'(w ? hs_w : hs), 32'(ehs));
        chk({tag, "_vs"}, 32'(w ? vs_w : vs), 32'(evs));
    endtask

    // Cell index of pixel (h,v) is on the outputs after edge 2p+2.
    task automatic cel(input string tag, input bit w, input int h, input int v, input int ex, input int ey);
        to(2 * (v * (w ? WHT : HT) + h) + 2);
        chk({tag, "_x"}, 32'(w ? cx_w : cx), 32'(ex));
        chk({tag, "_y"}, 32'(w ? cy_w : cy), 32'(ey));
    endtask

    task automatic next_frame(input string tag, input bit w);
        int len;
        len = w ? WFRAME : FRAME;
        to(len - 1);
        chk({tag, "_fs_early"}, 32'(w ? fs_w : fs), 32'd0);
        to(len);
        chk({tag, "_fs"}, 32'(w ? fs_w : fs), 32'd1);
        cur = 0;
    endtask

    initial begin
        rst_n   = 1'b0;
        rst_n_w = 1'b0;
        fb      = '0;
        fb[39]  = 1'b1;   // cell (0,0)
        fb[76]  = 1'b1;   // cell (3,1)
        fb_w    = '0;
        fb_w[39] = 1'b1;  // cell (0,0)
        fb_w[0]  = 1'b1;  // cell (39,0)

        repeat (3) @(posedge clock);
        #1;
        chk("rst_rgb", 32'(rgb), 32'h0);
        chk("rst_hs", 32'(hs), 32'd1);
        chk("rst_vs", 32'(vs), 32'd1);
        chk("rst_cx", 32'(cx), 32'd0);
        chk("rst_cy", 32'(cy), 32'd0);
        chk("rst_fs", 32'(fs), 32'd0);
        chk("rst_w_hs", 32'(hs_w), 32'd1);

        @(negedge clock);
        rst_n = 1'b1;
        cur = 0;

        // Frame 0: shadow still empty, check sync windows and cell index
        px("f0_empty", 0, 0, 0, 12'h000);
        syn("hs_before", 0, 67, 0, 1, 1);
        syn("hs_first", 0, 68, 0, 0, 1);
        syn("hs_last", 0, 75, 0, 0, 1);
        syn("hs_after", 0, 76, 0, 1, 1);
        syn("hs_line1", 0, 68, 1, 0, 1);
        cel("cell_blank", 0, 70, 5, 0, 0);
        cel("cell_vis", 0, 50, 20, 3, 1);
        syn("vs_before", 0, 0, 33, 1, 1);
        syn("vs_first", 0, 0, 34, 1, 0);
        syn("vs_last", 0, 79, 35, 1, 0);
        syn("vs_after", 0, 0, 36, 1, 1);
        next_frame("f0", 0);
        to(1);
        chk("fs_width", 32'(fs), 32'd0);

        // Frame 1: latched image, mid-frame framebuffer change must not show
        to(2);
        chk("lat_early", 32'(rgb), 32'h0);
        px("f1_00", 0, 0, 0, 12'hFFF);
        px("f1_15_0", 0, 15, 0, 12'hFFF);
        px("f1_16_0", 0, 16, 0, ul(16, 0));
        px("f1_63_0", 0, 63, 0, ul(63, 0));
        px("f1_porch", 0, 64, 0, 12'h000);
        px("f1_5_10", 0, 5, 10, 12'hFFF);
        fb = '0;
        fb[38] = 1'b1;    // cell (1,0)
        px("f1_15_15", 0, 15, 15, 12'hFFF);
        px("f1_0_16", 0, 0, 16, ul(0, 16));
        px("f1_48_16", 0, 48, 16, 12'hFFF);
        px("f1_63_31", 0, 63, 31, 12'hFFF);
        next_frame("f1", 0);

        // Frame 2: new image; clear framebuffer after this frame's latch
        px("f2_00", 0, 0, 0, ul(0, 0));
        px("f2_16_0", 0, 16, 0, 12'hFFF);
        px("f2_31_15", 0, 31, 15, 12'hFFF);
        px("f2_48_16", 0, 48, 16, ul(48, 16));
        to(5200);
        fb = '0;
        next_frame("f2", 0);

        // Frame 3: image kept; reset mid-frame
        px("f3_16_0", 0, 16, 0, 12'hFFF);
        px("f3_20_5", 0, 20, 5, 12'hFFF);
        chk("pre_rst_cx", 32'(cx), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rgb", 32'(rgb), 32'h0);
        chk("mid_rst_hs", 32'(hs), 32'd1);
        chk("mid_rst_vs", 32'(vs), 32'd1);
        chk("mid_rst_cx", 32'(cx), 32'd0);
        chk("mid_rst_fs", 32'(fs), 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        cur = 0;
        px("post_rst_shadow", 0, 16, 0, 12'h000);
        next_frame("post_rst", 0);

        // Full-width instance: default horizontal timing and column 39
        rst_n = 1'b0;
        @(negedge clock);
        rst_n_w = 1'b1;
        cur = 0;
        px("w0_empty", 1, 0, 0, 12'h000);
        syn("w_hs_before", 1, 655, 0, 1, 1);
        syn("w_hs_first", 1, 656, 0, 0, 1);
        syn("w_hs_last", 1, 751, 0, 0, 1);
        syn("w_hs_after", 1, 752, 0, 1, 1);
        syn("w_hs_line1", 1, 656, 1, 0, 1);
        syn("w_vs_before", 1, 0, 16, 1, 1);
        syn("w_vs_first", 1, 0, 17, 1, 0);
        syn("w_vs_last", 1, 799, 17, 1, 0);
        syn("w_vs_after", 1, 0, 18, 1, 1);
        next_frame("w0", 1);

        px("w1_00", 1, 0, 0, 12'hFFF);
        px("w1_15_0", 1, 15, 0, 12'hFFF);
        px("w1_16_0", 1, 16, 0, ul(16, 0));
        px("w1_623_0", 1, 623, 0, ul(623, 0));
        cel("w1_cell39", 1, 624, 0, 39, 0);
        px("w1_624_0", 1, 624, 0, 12'hFFF);
        cel("w1_cell39_end", 1, 639, 0, 39, 0);
        px("w1_639_0", 1, 639, 0, 12'hFFF);
        cel("w1_cell_porch", 1, 640, 0, 0, 0);
        px("w1_porch", 1, 640, 0, 12'h000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
